// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings and the per-stage control bundle for the ARM-subset pipeline controller.
package pipeline_ctrl_pkg;

    localparam int COND_W = 4;

    typedef enum logic [1:0] {
        OP_DP  = 2'b00,
        OP_MEM = 2'b01,
        OP_BR  = 2'b10,
        OP_NOP = 2'b11
    } op_e;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
    localparam logic [COND_W-1:0] COND_NE = 4'b0001;
    localparam logic [COND_W-1:0] COND_CS = 4'b0010;
    localparam logic [COND_W-1:0] COND_CC = 4'b0011;
    localparam logic [COND_W-1:0] COND_MI = 4'b0100;
    localparam logic [COND_W-1:0] COND_PL = 4'b0101;
    localparam logic [COND_W-1:0] COND_VS = 4'b0110;
    localparam logic [COND_W-1:0] COND_VC = 4'b0111;
    localparam logic [COND_W-1:0] COND_HI = 4'b1000;
    localparam logic [COND_W-1:0] COND_LS = 4'b1001;
    localparam logic [COND_W-1:0] COND_GE = 4'b1010;
    localparam logic [COND_W-1:0] COND_LT = 4'b1011;
    localparam logic [COND_W-1:0] COND_GT = 4'b1100;
    localparam logic [COND_W-1:0] COND_LE = 4'b1101;
    localparam logic [COND_W-1:0] COND_AL = 4'b1110;

    localparam logic [1:0] IMM_ROT8 = 2'b00;
    localparam logic [1:0] IMM_12   = 2'b01;
    localparam logic [1:0] IMM_24   = 2'b10;

    localparam logic [1:0] ALU_SRC_REG   = 2'b00;
    localparam logic [1:0] ALU_SRC_IMM   = 2'b01;
    localparam logic [1:0] ALU_SRC_SHIFT = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       memto_reg;
        logic [1:0] alu_src;
        logic [3:0] alu_control;
        logic       shifter_mux;
        logic       branch;
        logic       flag_w;
        logic       pcs;
        logic       link;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/pipeline_controller_cond_unit.sv
// NZCV flags register and ARM condition-field evaluation for the Execute stage.
module cond_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [COND_W-1:0] i_cond,
    input  logic              i_flag_we,
    input  logic [3:0]        i_flags,
    output logic              o_cond_ex
);

    logic [3:0] r_flags;

    // Flags are ordered {N,Z,C,V}; NV (1111) never executes.
    function automatic logic cond_eval(input logic [COND_W-1:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        {n, z, c, v} = flags;
        case (cond)
            COND_EQ: cond_eval = z;
            COND_NE: cond_eval = ~z;
            COND_CS: cond_eval = c;
            COND_CC: cond_eval = ~c;
            COND_MI: cond_eval = n;
            COND_PL: cond_eval = ~n;
            COND_VS: cond_eval = v;
            COND_VC: cond_eval = ~v;
            COND_HI: cond_eval = c & ~z;
            COND_LS: cond_eval = ~c | z;
            COND_GE: cond_eval = (n == v);
            COND_LT: cond_eval = (n != v);
            COND_GT: cond_eval = ~z & (n == v);
            COND_LE: cond_eval = z | (n != v);
            COND_AL: cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    assign o_cond_ex = cond_eval(i_cond, r_flags);

    // Flags register: loads only when the flag-setting instruction actually executes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else if (i_flag_we & o_cond_ex) begin
            r_flags <= i_flags;
        end
    end

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline control unit: decodes in D, carries control through E/M/W and gates on the E-stage condition.
module pipeline_controller
    import pipeline_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrD,
    input  logic        CO,
    input  logic        OVF,
    input  logic        N,
    input  logic        Z,
    input  logic        FlushE,
    output logic [1:0]  RegSrcD,
    output logic [1:0]  ImmSrcD,
    output logic [1:0]  ALUSrcE,
    output logic [3:0]  ALUControlE,
    output logic        ShifterMuxesE,
    output logic        BranchTakenE,
    output logic        MemtoRegE,
    output logic        PCSrcD,
    output logic        PCSrcE,
    output logic        PCSrcM,
    output logic        MemWriteM,
    output logic        RegWriteM,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic        PCSrcW,
    output logic        RegSrcW
);

    op_e               w_op;
    logic [3:0]        w_cmd;
    logic [3:0]        w_rd;
    ctrl_t             w_ctrl_d;
    logic [1:0]        w_imm_src;
    logic [1:0]        w_reg_src;
    logic              w_cond_ex;
    logic              w_unused_bits;

    ctrl_t             r_ctrl_e;
    logic [COND_W-1:0] r_cond_e;
    logic              r_reg_write_m, r_mem_write_m, r_memto_reg_m, r_pcsrc_m, r_link_m;
    logic              r_reg_write_w, r_memto_reg_w, r_pcsrc_w, r_link_w;

    assign w_op          = op_e'(InstrD[27:26]);
    assign w_cmd         = InstrD[24:21];
    assign w_rd          = InstrD[15:12];
    assign w_unused_bits = ^{InstrD[19:16], InstrD[11:0]};

    // Decode: op 11 and anything unrecognised fall through as an all-zero NOP.
    always_comb begin
        w_ctrl_d  = CTRL_NOP;
        w_imm_src = IMM_ROT8;
        w_reg_src = 2'b00;
        case (w_op)
            OP_DP: begin
                w_imm_src            = IMM_ROT8;
                w_ctrl_d.alu_src     = ALU_SRC_SHIFT;
                w_ctrl_d.shifter_mux = InstrD[25];
                w_ctrl_d.alu_control = w_cmd;
                w_ctrl_d.reg_write   = (w_cmd[3:2] != 2'b10);
                w_ctrl_d.flag_w      = InstrD[20];
            end
            OP_MEM: begin
                w_imm_src            = IMM_12;
                w_ctrl_d.alu_src     = ALU_SRC_IMM;
                w_ctrl_d.alu_control = InstrD[23] ? CMD_ADD : CMD_SUB;
                if (InstrD[20]) begin
                    w_ctrl_d.reg_write = 1'b1;
                    w_ctrl_d.memto_reg = 1'b1;
                end else begin
                    w_ctrl_d.mem_write = 1'b1;
                    w_reg_src[1]       = 1'b1;
                end
            end
            OP_BR: begin
                w_imm_src            = IMM_24;
                w_ctrl_d.alu_src     = ALU_SRC_IMM;
                w_ctrl_d.alu_control = CMD_ADD;
                w_ctrl_d.branch      = 1'b1;
                w_reg_src[0]         = 1'b1;
                if (InstrD[24]) begin
                    w_ctrl_d.reg_write = 1'b1;
                    w_ctrl_d.link      = 1'b1;
                end else begin
                    w_ctrl_d.link      = 1'b0;
                end
            end
            default: begin
                w_ctrl_d = CTRL_NOP;
            end
        endcase
        w_ctrl_d.pcs = w_ctrl_d.reg_write & (w_rd == 4'd15) & ~w_ctrl_d.branch;
    end

    assign RegSrcD = w_reg_src;
    assign ImmSrcD = w_imm_src;
    assign PCSrcD  = w_ctrl_d.pcs;

    // D->E register; a flush loads the NOP bundle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl_e <= CTRL_NOP;
            r_cond_e <= 4'b0000;
        end else if (FlushE) begin
            r_ctrl_e <= CTRL_NOP;
            r_cond_e <= 4'b0000;
        end else begin
            r_ctrl_e <= w_ctrl_d;
            r_cond_e <= InstrD[31:28];
        end
    end

    cond_unit u_cond (
        .clk       (clk),
        .reset     (reset),
        .i_cond    (r_cond_e),
        .i_flag_we (r_ctrl_e.flag_w),
        .i_flags   ({N, Z, CO, OVF}),
        .o_cond_ex (w_cond_ex)
    );

    assign ALUSrcE       = r_ctrl_e.alu_src;
    assign ALUControlE   = r_ctrl_e.alu_control;
    assign ShifterMuxesE = r_ctrl_e.shifter_mux;
    assign MemtoRegE     = r_ctrl_e.memto_reg;
    assign PCSrcE        = r_ctrl_e.pcs;
    assign BranchTakenE  = r_ctrl_e.branch & w_cond_ex;

    // E->M and M->W registers; writes are squashed here when the condition fails.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reg_write_m <= 1'b0;
            r_mem_write_m <= 1'b0;
            r_memto_reg_m <= 1'b0;
            r_pcsrc_m     <= 1'b0;
            r_link_m      <= 1'b0;
            r_reg_write_w <= 1'b0;
            r_memto_reg_w <= 1'b0;
            r_pcsrc_w     <= 1'b0;
            r_link_w      <= 1'b0;
        end else begin
            r_reg_write_m <= r_ctrl_e.reg_write & w_cond_ex;
            r_mem_write_m <= r_ctrl_e.mem_write & w_cond_ex;
            r_memto_reg_m <= r_ctrl_e.memto_reg;
            r_pcsrc_m     <= r_ctrl_e.pcs & w_cond_ex;
            r_link_m      <= r_ctrl_e.link & w_cond_ex;
            r_reg_write_w <= r_reg_write_m;
            r_memto_reg_w <= r_memto_reg_m;
            r_pcsrc_w     <= r_pcsrc_m;
            r_link_w      <= r_link_m;
        end
    end

    assign PCSrcM    = r_pcsrc_m;
    assign MemWriteM = r_mem_write_m;
    assign RegWriteM = r_reg_write_m;
    assign RegWriteW = r_reg_write_w;
    assign MemtoRegW = r_memto_reg_w;
    assign PCSrcW    = r_pcsrc_w;
    assign RegSrcW   = r_link_w;

endmodule
